// File: rtl/maze_pkg.sv
// Shared types and constants for the maze ray-tracing frame scheduler.
// Holds the scheduler state enum, the draw-mode codes and the default raster size.
package maze_pkg;

    typedef enum logic [1:0] {
        STILL    = 2'd0,
        INIT_CAM = 2'd1,
        DRAW     = 2'd2,
        DRAIN    = 2'd3
    } sched_state_t;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_MOVE   = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    localparam int H_RES_DEF = 800;
    localparam int V_RES_DEF = 600;

endpackage

// File: rtl/render_pix_cnt.sv
// Raster-order x/y pixel counter with line wrap and last-pixel detect.
// Advances one pixel per i_adv; wraps to (0,0) after the final pixel.
module render_pix_cnt
    import maze_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_adv,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic         o_last
);

    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         w_x_end;
    logic         w_y_end;

    assign w_x_end = (r_x == W'(H_RES - 1));
    assign w_y_end = (r_y == W'(V_RES - 1));
    assign o_last  = w_x_end & w_y_end;
    assign o_x     = r_x;
    assign o_y     = r_y;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/render_sched.sv
// Frame-render scheduler: camera init, credit-throttled raster issue, drain.
// Optional RENDER_SCHED_PERF_EN adds the frame_cycles performance counter.
module render_sched
    import maze_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int W     = 12,
    parameter int CRD   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         move_req,
    input  logic         rot_req,
    output logic         cam_start,
    input  logic         cam_done,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [W-1:0] pix_x,
    output logic [W-1:0] pix_y,
    output logic         pix_last,
    input  logic         ret_valid,
    output logic [1:0]   mode,
    output logic         busy,
`ifdef RENDER_SCHED_PERF_EN
    output logic [31:0]  frame_cycles,
`endif
    output logic         frame_done
);

    localparam int CW = $clog2(CRD + 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [CW-1:0] r_infl;
    logic [CW-1:0] w_infl_nxt;
    logic          r_cam_start;
    logic          r_frame_done;
    logic          r_pend;
    logic [1:0]    r_pend_mode;
    logic [1:0]    r_mode;
    logic [1:0]    w_mode_nxt;
    logic [1:0]    w_req_mode;
    logic          w_req;
    logic          w_xfer;
    logic          w_last;
    logic          w_done;

    assign w_req      = move_req | rot_req;
    assign w_req_mode = rot_req ? MODE_ROTATE : MODE_MOVE;
    assign pix_valid  = (r_state == DRAW) && (r_infl < CW'(CRD));
    assign w_xfer     = pix_valid & pix_ready;
    assign pix_last   = w_last & pix_valid;
    assign cam_start  = r_cam_start;
    assign frame_done = r_frame_done;
    assign mode       = r_mode;
    assign busy       = (r_state != STILL);

    render_pix_cnt #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .W     (W)
    ) u_pix_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == INIT_CAM),
        .i_adv  (w_xfer),
        .o_x    (pix_x),
        .o_y    (pix_y),
        .o_last (w_last)
    );

    // A retire with nothing in flight is dropped so stale returns after reset are harmless.
    always_comb begin
        w_infl_nxt = r_infl;
        if (w_xfer && !ret_valid) begin
            w_infl_nxt = r_infl + 1'b1;
        end else if (!w_xfer && ret_valid && (r_infl != '0)) begin
            w_infl_nxt = r_infl - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_done      = 1'b0;
        unique case (r_state)
            STILL: begin
                if (w_req) begin
                    w_state_nxt = INIT_CAM;
                    w_mode_nxt  = w_req_mode;
                end
            end
            INIT_CAM: begin
                if (cam_done) begin
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_infl_nxt == '0) begin
                    w_done = 1'b1;
                    if (w_req) begin
                        w_state_nxt = INIT_CAM;
                        w_mode_nxt  = w_req_mode;
                    end else if (r_pend) begin
                        w_state_nxt = INIT_CAM;
                        w_mode_nxt  = r_pend_mode;
                    end else begin
                        w_state_nxt = STILL;
                        w_mode_nxt  = MODE_NONE;
                    end
                end
            end
            default: begin
                w_state_nxt = STILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_infl       <= '0;
            r_cam_start  <= 1'b0;
            r_frame_done <= 1'b0;
            r_mode       <= MODE_NONE;
            r_pend       <= 1'b0;
            r_pend_mode  <= MODE_NONE;
        end else begin
            r_infl       <= w_infl_nxt;
            r_cam_start  <= (w_state_nxt == INIT_CAM) && (r_state != INIT_CAM);
            r_frame_done <= w_done;
            r_mode       <= w_mode_nxt;
            if (w_done) begin
                r_pend <= 1'b0;
            end else if (w_req && (r_state != STILL)) begin
                r_pend      <= 1'b1;
                r_pend_mode <= w_req_mode;
            end
        end
    end

`ifdef RENDER_SCHED_PERF_EN
    logic [31:0] r_cyc;
    logic [31:0] r_frame_cycles;

    // r_cyc counts cycles since cam_start inclusive of the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc          <= '0;
            r_frame_cycles <= '0;
        end else begin
            r_cyc <= r_cam_start ? 32'd1 : r_cyc + 32'd1;
            if (r_frame_done) begin
                r_frame_cycles <= r_cyc + 32'd1;
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

endmodule

// File: tb/tb_render_sched.sv
// Scoreboard bench for render_sched with a 4x2 raster and two credits.
module tb_render_sched;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int W   = 12;
    localparam int CRD = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         move_req;
    logic         rot_req;
    logic         cam_start;
    logic         cam_done;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] pix_x;
    logic [W-1:0] pix_y;
    logic         pix_last;
    logic         ret_valid;
    logic [1:0]   mode;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    render_sched #(
        .H_RES (H),
        .V_RES (V),
        .W     (W),
        .CRD   (CRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .move_req   (move_req),
        .rot_req    (rot_req),
        .cam_start  (cam_start),
        .cam_done   (cam_done),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_last   (pix_last),
        .ret_valid  (ret_valid),
        .mode       (mode),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         last;
    } pix_t;

    typedef struct packed {
        logic       busy;
        logic       cs;
        logic [1:0] mode;
    } fd_t;

    pix_t pix_q[$];
    fd_t  fd_q[$];
    pix_t exp_pix;
    fd_t  exp_fd;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_fd  = 0;
    logic xf;
    logic seen;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        pix_t p;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p.x    = W'(x);
                p.y    = W'(y);
                p.last = (x == H - 1) && (y == V - 1);
                pix_q.push_back(p);
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: pops expected pixels and frame-end conditions as the DUT produces them.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (pix_valid && pix_ready) begin
                if (pix_q.size() == 0) begin
                    chk("pix_extra", 32'd1, 32'd0);
                end else begin
                    exp_pix = pix_q.pop_front();
                    chk("pix", {7'd0, pix_x, pix_y, pix_last}, {7'd0, exp_pix});
                end
            end
            if (frame_done) begin
                n_fd++;
                if (fd_q.size() == 0) begin
                    chk("fd_extra", 32'd1, 32'd0);
                end else begin
                    exp_fd = fd_q.pop_front();
                    chk("fd_state", {28'd0, busy, cam_start, mode}, {28'd0, exp_fd});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        move_req  = 1'b0;
        rot_req   = 1'b0;
        cam_done  = 1'b0;
        pix_ready = 1'b0;
        ret_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        smp();
        chk("init_busy", busy, 0);

        // Basic frame with immediate retire
        nxt(); move_req = 1'b1; smp();
        chk("still_busy", busy, 0);
        nxt(); move_req = 1'b0; smp();
        chk("cam_start", cam_start, 1);
        chk("mode_move", mode, 2'b10);
        nxt(); smp();
        chk("cam_start_once", cam_start, 0);
        nxt(); cam_done = 1'b1; push_frame(); smp();
        chk("init_no_valid", pix_valid, 0);
        nxt(); cam_done = 1'b0; pix_ready = 1'b1; smp();
        chk("first_valid", pix_valid, 1);
        xf = pix_valid & pix_ready;
        fd_q.push_back('{busy: 1'b0, cs: 1'b0, mode: 2'b00});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nxt(); ret_valid = xf; smp();
            xf = pix_valid & pix_ready;
            seen = frame_done;
        end
        chk("basic_fd_seen", seen, 1);
        nxt(); ret_valid = 1'b0; pix_ready = 1'b0; smp();
        chk("basic_busy_off", busy, 0);
        chk("basic_fd_once", frame_done, 0);

        // Credit throttle, simultaneous retire, pending rotate
        nxt(); move_req = 1'b1; smp();
        nxt(); move_req = 1'b0; smp();
        chk("crd_cam_start", cam_start, 1);
        nxt(); cam_done = 1'b1; push_frame(); smp();
        nxt(); cam_done = 1'b0; pix_ready = 1'b1; smp();
        chk("crd_v0", pix_valid, 1);
        nxt(); rot_req = 1'b1; smp();
        nxt(); rot_req = 1'b0; smp();
        chk("crd_stall", pix_valid, 0);
        chk("crd_hold_xy", {pix_x, pix_y}, {12'd2, 12'd0});
        nxt(); smp();
        chk("crd_stall2", pix_valid, 0);
        nxt(); ret_valid = 1'b1; smp();
        chk("crd_ret_cycle", pix_valid, 0);
        nxt(); smp();
        chk("crd_reopen", pix_valid, 1);
        nxt(); ret_valid = 1'b0; smp();
        chk("simul_keep1", pix_valid, 1);
        nxt(); smp();
        chk("simul_full", pix_valid, 0);
        fd_q.push_back('{busy: 1'b1, cs: 1'b1, mode: 2'b11});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nxt(); ret_valid = 1'b1; smp();
            seen = frame_done;
        end
        chk("chain_fd_seen", seen, 1);
        nxt(); ret_valid = 1'b0; pix_ready = 1'b0; smp();
        chk("chain_busy", busy, 1);
        chk("chain_cs_once", cam_start, 0);
        chk("chain_mode", mode, 2'b11);

        // Backpressure on the chained frame, then reset mid-DRAW
        nxt(); cam_done = 1'b1; push_frame(); smp();
        nxt(); cam_done = 1'b0; smp();
        chk("bp_first_valid", pix_valid, 1);
        for (int i = 0; i < 5; i++) begin
            nxt(); smp();
            chk("bp_valid", pix_valid, 1);
            chk("bp_xy", {pix_x, pix_y}, 24'd0);
        end
        nxt(); pix_ready = 1'b1; smp();
        nxt(); smp();
        nxt(); pix_ready = 1'b0; smp();
        chk("pre_rst_full", pix_valid, 0);
        nxt(); rst = 1'b1; pix_q.delete();
        nxt();
        nxt();
        nxt(); rst = 1'b0; smp();
        chk("rst_all", {cam_start, pix_valid, pix_x, pix_y, pix_last,
                        mode, busy, frame_done}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, 0);

        // Stale retire, priority, credit restart from zero
        nxt(); ret_valid = 1'b1; smp();
        nxt(); ret_valid = 1'b0; move_req = 1'b1; rot_req = 1'b1; smp();
        nxt(); move_req = 1'b0; rot_req = 1'b0; smp();
        chk("prio_cs", cam_start, 1);
        chk("prio_mode", mode, 2'b11);
        nxt(); cam_done = 1'b1; push_frame(); smp();
        nxt(); cam_done = 1'b0; smp();
        chk("sat_valid", pix_valid, 1);
        nxt(); pix_ready = 1'b1; smp();
        nxt(); smp();
        nxt(); smp();
        chk("sat_full", pix_valid, 0);
        fd_q.push_back('{busy: 1'b0, cs: 1'b0, mode: 2'b00});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nxt(); ret_valid = 1'b1; smp();
            seen = frame_done;
        end
        chk("last_fd_seen", seen, 1);
        nxt(); ret_valid = 1'b0; pix_ready = 1'b0; smp();
        chk("last_busy_off", busy, 0);
        chk("last_mode_clr", mode, 0);

        chk("pix_q_empty", pix_q.size(), 0);
        chk("fd_q_empty", fd_q.size(), 0);
        chk("fd_count", n_fd, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
